// File: rtl/parallel_to_serial_if.sv
// ---------------------------------------------------------------------------
// parallel_to_serial_if
//   Bundles the word-input handshake and the serial output of the
//   parallel_to_serial block.
//
//   Handshake: a word on din moves into the block on a rising clock edge
//   where din_valid && din_ready are both high. din_ready is a pure
//   function of internal registers and never looks at din_valid. The
//   serial side has no backpressure: every cycle with dout_valid high
//   carries one bit, and the consumer must take it.
//
//   Signals:
//     din        [DATA_WIDTH] parallel word offered by the upstream
//     din_valid  [1]          din holds a word
//     din_ready  [1]          block can take a word this cycle
//     dout       [1]          serial bit, MSB first
//     dout_valid [1]          dout carries a bit this cycle
//     dout_last  [1]          dout is bit 0 of the current word
//     dbg_state  [1]          FSM state (0 = IDLE, 1 = SHIFT), observation only
//
//   Modports: master = upstream/consumer side, slave = serializer side.
// ---------------------------------------------------------------------------
interface parallel_to_serial_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic                  dout;
  logic                  dout_valid;
  logic                  dout_last;
  logic                  dbg_state;

  modport master (
    output din, din_valid,
    input  din_ready, dout, dout_valid, dout_last, dbg_state
  );

  modport slave (
    input  din, din_valid,
    output din_ready, dout, dout_valid, dout_last, dbg_state
  );
endinterface

// File: rtl/parallel_to_serial.sv
// ---------------------------------------------------------------------------
// parallel_to_serial
//   Serializer: takes a DATA_WIDTH-bit word over a valid/ready handshake and
//   shifts it out one bit per clock, MSB first, so that a shift-into-LSB
//   receiver rebuilds the word after DATA_WIDTH valid cycles. A one-word
//   holding register lets the next word be accepted while the current one
//   is still shifting, so back-to-back words stream with no idle cycle.
//
//   Ports:
//     clk    rising-edge clock
//     resetn asynchronous active-low reset; drops any in-flight word
//     bus    parallel_to_serial_if.slave (din/din_valid/din_ready in,
//            dout/dout_valid/dout_last out, dbg_state for observation)
// ---------------------------------------------------------------------------
module parallel_to_serial #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  parallel_to_serial_if.slave   bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;

  logic w_din_ready;
  logic w_accept;
  logic w_last_bit;

  // Ready depends only on the holding register, so the upstream can never
  // form a combinational loop through din_valid.
  assign w_din_ready = !r_hold_full;
  assign w_accept    = bus.din_valid && w_din_ready;
  assign w_last_bit  = (r_cnt == LAST_CNT);

  assign bus.din_ready  = w_din_ready;
  assign bus.dout       = r_sr[DATA_WIDTH-1];
  assign bus.dout_valid = (r_state == ST_SHIFT);
  assign bus.dout_last  = (r_state == ST_SHIFT) && w_last_bit;
  assign bus.dbg_state  = r_state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sr    <= bus.din;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (!w_last_bit) begin
            r_sr  <= r_sr << 1;
            r_cnt <= r_cnt + 1'b1;
            if (w_accept) begin
              r_hold      <= bus.din;
              r_hold_full <= 1'b1;
            end
          end else begin
            // Last bit of the word: chain straight into the next one if any.
            // A held word and a fresh accept cannot coincide because ready
            // is low whenever the holding register is full.
            r_cnt <= '0;
            if (r_hold_full) begin
              r_sr        <= r_hold;
              r_hold_full <= 1'b0;
            end else if (w_accept) begin
              r_sr <= bus.din;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
